stdin_uart_rx: RTL and testbench

UART receiver with a byte FIFO that supplies the processor's input (`,`) instruction from the board's `uart_rx_pin`. It sits upstream of `proc` and mirrors `uart_tx` on the output side. Serial 8N1 frames are deserialized, checked and queued. The processor pops bytes through a show-ahead valid/read handshake, and stalls on `en` while the FIFO is empty.

---
 rtl/stdin_uart_rx_pkg.sv | 17 +
 rtl/stdin_uart_rx_if.sv | 34 +++
 rtl/stdin_uart_rx_sync_fifo.sv | 49 ++++
 rtl/stdin_uart_rx.sv | 169 ++++++++++++++++
 tb/tb_stdin_uart_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/stdin_uart_rx_pkg.sv
// Shared definitions for the stdin UART receiver: FSM state encodings,
// the frame width and the default baud divisor.
package stdin_rx_pkg;

    localparam int FRAME_BITS = 8;

    // Clock cycles per bit at 115200 baud with the 12 MHz board clock.
    localparam int B115200 = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/stdin_uart_rx_if.sv
// Pop handshake and status bundle between the stdin receiver (slave) and the
// processor input stage (master).
interface stdin_uart_rx_if
    import stdin_rx_pkg::*;
#(
    parameter int LEVEL_W = 5
);

    logic                  rd_en;
    logic [FRAME_BITS-1:0] data;
    logic                  valid;
    logic [LEVEL_W-1:0]    level;
    logic                  overrun;
    logic                  frame_err;

    modport master (
        output rd_en,
        input  data,
        input  valid,
        input  level,
        input  overrun,
        input  frame_err
    );

    modport slave (
        input  rd_en,
        output data,
        output valid,
        output level,
        output overrun,
        output frame_err
    );

endinterface

// File: rtl/stdin_uart_rx_sync_fifo.sv
// Show-ahead circular FIFO with extended read/write pointers; the head reads
// as zero while empty. A push into a full FIFO only succeeds alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept the push.
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr - rd_ptr;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/stdin_uart_rx.sv
// 8N1 UART receiver feeding a byte FIFO for the processor's input instruction.
// Define STDIN_RX_FRAME_CHECK_EN to drop bytes with a low stop bit and pulse frame_err.
module stdin_uart_rx
    import stdin_rx_pkg::*;
#(
    parameter int BAUD       = B115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    stdin_uart_rx_if.slave   bus
);

    localparam int CNT_W = $clog2(BAUD);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BAUD - BAUD / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic rx_s1;
    logic rx_sync;
    logic rx_prev;
    logic fall;
    logic tick;

    rx_state_t             state,   state_n;
    logic [CNT_W-1:0]      cnt,     cnt_n;
    logic [BIT_W-1:0]      bit_idx, bit_idx_n;
    logic [FRAME_BITS-1:0] shift,   shift_n;
    logic                  push;
    logic                  overrun_q;

    logic [FRAME_BITS-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;

    // Synchronizer resets to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev && !rx_sync;
    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

`ifdef STDIN_RX_FRAME_CHECK_EN
    logic frame_bad;
    logic frame_err_q;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        push      = 1'b0;
`ifdef STDIN_RX_FRAME_CHECK_EN
        frame_bad = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                // Preload so the first tick lands half a bit after the edge.
                if (fall) begin
                    state_n = START;
                    cnt_n   = CNT_LOAD;
                end
            end
            START: begin
                cnt_n = cnt + CNT_ONE;
                if (tick) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + CNT_ONE;
                if (tick) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[FRAME_BITS-1:1]};
                    if (bit_idx == BIT_LAST) state_n = STOP;
                    else                     bit_idx_n = bit_idx + BIT_ONE;
                end
            end
            STOP: begin
                cnt_n = cnt + CNT_ONE;
                if (tick) begin
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef STDIN_RX_FRAME_CHECK_EN
                    if (rx_sync) push      = 1'b1;
                    else         frame_bad = 1'b1;
`else
                    push = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (shift),
        .pop       (bus.rd_en),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A full FIFO implies valid, so rd_en alone decides whether the push survives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && fifo_full && !bus.rd_en;
        end
    end

`ifdef STDIN_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) frame_err_q <= 1'b0;
        else       frame_err_q <= frame_bad;
    end
    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.data    = fifo_head;
    assign bus.valid   = !fifo_empty;
    assign bus.level   = fifo_level;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_stdin_uart_rx.sv
// Scoreboard bench for stdin_uart_rx: frames are driven serially, expected bytes
// are queued as each frame is sent and compared as the processor side pops them.
module tb_stdin_uart_rx;
    import stdin_rx_pkg::*;

    localparam int BAUD    = 16;
    localparam int DEPTH   = 4;
    localparam int LEVEL_W = 3;
    localparam int LAT     = 3 + BAUD / 2 + 9 * BAUD;

    logic clk;
    logic rstn;
    logic rx;

    int checks       = 0;
    int errors       = 0;
    int overrun_seen = 0;
    int frame_seen   = 0;
    int exp_overrun  = 0;
    int exp_frame    = 0;
    int lat          = 0;

    logic [7:0] exp_q [$];

    stdin_uart_rx_if #(.LEVEL_W(LEVEL_W)) bus ();

    stdin_uart_rx #(
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.overrun === 1'b1)   overrun_seen++;
        if (bus.frame_err === 1'b1) frame_seen++;
    end

    task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
`ifdef STDIN_RX_FRAME_CHECK_EN
        if (!stop_bit) begin
            exp_frame++;
            return;
        end
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                      exp_overrun++;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_byte(b, stop_bit);
        model_frame(b, stop_bit);
    endtask

    task automatic pop_and_check(input string tag);
        check_output({tag, "_valid"}, 32'(bus.valid), 32'(exp_q.size() != 0));
        check_output({tag, "_data"}, 32'(bus.data), 32'(exp_head()));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_output({tag, "_level"}, 32'(bus.level), 32'(exp_q.size()));
        check_output({tag, "_next"}, 32'(bus.data), 32'(exp_head()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_data"}, 32'(bus.data), 32'h0);
        check_output({tag, "_valid"}, 32'(bus.valid), 32'h0);
        check_output({tag, "_level"}, 32'(bus.level), 32'h0);
        check_output({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
        check_output({tag, "_frame_err"}, 32'(bus.frame_err), 32'h0);
    endtask

    initial begin
        rx        = 1'b1;
        rstn      = 1'b0;
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single byte 0x41 with latency");
        fork
            send_frame(8'h41, 1'b1);
            begin
                lat = 0;
                while (bus.valid !== 1'b1 && lat < 4 * LAT) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check_output("t1_latency", 32'(lat), 32'(LAT));
        check_output("t1_level", 32'(bus.level), 32'(exp_q.size()));
        pop_and_check("t1");

        $display("[TB] false start");
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check_output("t2_level", 32'(bus.level), 32'h0);
        check_output("t2_valid", 32'(bus.valid), 32'h0);

        $display("[TB] overrun on full FIFO");
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        check_output("t3_no_overrun", 32'(overrun_seen), 32'h0);
        check_output("t3_level_full", 32'(bus.level), 32'(DEPTH));
        send_frame(8'h05, 1'b1);
        check_output("t3_overrun", 32'(overrun_seen), 32'(exp_overrun));
        check_output("t3_level_after", 32'(bus.level), 32'(exp_q.size()));
        for (int i = 0; i < 4; i++) pop_and_check("t3_pop");
        pop_and_check("t3_empty_pop");

        $display("[TB] push and pop together while full");
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_byte(8'h06, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                check_output("t4_head_before", 32'(bus.data), 32'(exp_head()));
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
                void'(exp_q.pop_front());
                exp_q.push_back(8'h06);
                check_output("t4_level", 32'(bus.level), 32'(exp_q.size()));
                check_output("t4_head_after", 32'(bus.data), 32'(exp_head()));
            end
        join
        check_output("t4_overrun", 32'(overrun_seen), 32'(exp_overrun));
        for (int i = 0; i < 4; i++) pop_and_check("t4_pop");

        $display("[TB] low stop bit");
        send_frame(8'h7E, 1'b0);
        check_output("t5_frame_err", 32'(frame_seen), 32'(exp_frame));
        check_output("t5_level", 32'(bus.level), 32'(exp_q.size()));
        pop_and_check("t5");

        $display("[TB] reset mid-frame");
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_output("t6_level_queued", 32'(bus.level), 32'(exp_q.size()));
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (BAUD * 4 + BAUD / 2) @(negedge clk);
                rstn = 1'b0;
                #1;
                check_reset_outputs("t6_reset");
                exp_q.delete();
                repeat (10) @(negedge clk);
                rstn = 1'b1;
            end
        join
        repeat (BAUD) @(negedge clk);
        check_output("t6_level_idle", 32'(bus.level), 32'h0);
        send_frame(8'h5A, 1'b1);
        check_output("t6_level_after", 32'(bus.level), 32'(exp_q.size()));
        pop_and_check("t6");
        check_output("t6_overrun_total", 32'(overrun_seen), 32'(exp_overrun));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
